// File: rtl/if_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - RESET_PC_DEFAULT : default PC after reset.
//   - npc_op_e         : next-PC selector encodings, shared with the ctrl stage
//                        (a redirect is raised when this is not NPC_PLUS4 and
//                        the branch resolves taken).
//   - fetch_entry_t    : {pc, instr} record buffered toward decode.
//   - word_align()     : clears the byte-offset bits of an address.
// ---------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JALR   = 2'd3
  } npc_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Small show-ahead FIFO: the head entry is visible on head_data whenever
//   count != 0. Synchronous flush (wins over push/pop), asynchronous reset.
//   Ports:
//     clk, rst    clock, async active-high reset
//     flush       empty the FIFO at the next edge
//     push/push_data  write request; accepted when not full or popping
//     pop         remove the head (ignored when empty)
//     head_data   current head entry (undefined when count == 0)
//     count       number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // When full, a push is only legal because the head leaves this same cycle;
    // the write then lands in the slot being vacated.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed behind count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction fetch: owns the PC, issues in-order requests to instruction
//   memory, buffers responses and presents {pc, instr} to decode.
//   Ports:
//     clk, rst                         clock, async active-high reset
//     imem_req_valid/ready/addr        fetch request channel (addr word aligned)
//     imem_rsp_valid/data              in-order response channel
//     redirect_valid/pc                EX redirect (taken branch, jal, jalr)
//     if_valid/ready, if_pc/instr      handshake toward decode
// ---------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int CREDIT_W = CNT_W + 1;

  logic [31:0]         pc_q, pc_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [CNT_W-1:0]    buf_count, tag_count;
  logic [CREDIT_W-1:0] credit;
  logic [31:0]         tag_head;
  fetch_entry_t        buf_head, buf_push_data;
  logic                req_fire, rsp_take, rsp_push, if_fire;

  // Every buffered entry and every outstanding request holds a credit, so a
  // returning response always finds room in the buffer.
  assign credit         = {1'b0, inflight_q} + {1'b0, buf_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit < CREDIT_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take = imem_rsp_valid && (inflight_q != '0);
  // Wrong-path words (pending drops, or arriving during a redirect) are
  // consumed but never buffered; the tag queue only holds right-path PCs.
  assign rsp_push = rsp_take && (drop_q == '0) && !redirect_valid && (tag_count != '0);

  assign if_valid = (buf_count != '0);
  assign if_fire  = if_valid && if_ready;
  assign if_pc    = if_valid ? buf_head.pc    : 32'h0;
  assign if_instr = if_valid ? buf_head.instr : 32'h0;

  assign buf_push_data = '{pc: tag_head, instr: imem_rsp_data};

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !rsp_take)      inflight_d = inflight_q + CNT_W'(1);
    else if (rsp_take && !req_fire) inflight_d = inflight_q - CNT_W'(1);

    drop_d = drop_q;
    pc_d   = pc_q;
    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      drop_d = inflight_d;
      pc_d   = word_align(redirect_pc);
    end else begin
      if (rsp_take && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (req_fire)                   pc_d   = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= word_align(RESET_PC);
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // PC tags, written at issue and read back when the matching word returns.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32),
    .CNT_W (CNT_W)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_push),
    .head_data (tag_head),
    .count     (tag_count)
  );

  // {pc, instr} buffer toward decode.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data (buf_push_data),
    .pop       (if_fire),
    .head_data (buf_head),
    .count     (buf_count)
  );

endmodule
